// File: rtl/jesd204_tx_scrambler_64b66b.sv
// jesd204_tx_scrambler_64b66b
// Per-lane JESD204C 64B66B transmit scrambler (1 + x^39 + x^58, self-synchronous).
// Scrambles the 64-bit payload, forwards the sync header untouched, ties the
// adapter charisk to zero and flags illegal sync headers with a sticky error.
// Optional input register stage selects a latency of 1 or 2 cycles.

module jesd204_tx_scrambler_64b66b #(
  parameter int REGISTER_INPUTS = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scrambler_disable,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic [1:0]  in_header,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic [1:0]  out_header,
  output logic [3:0]  out_charisk,
  output logic        header_error
);

  // Stream bit k is x[63-k]; history s[j] is the scrambled bit sent j+1 places
  // earlier. Feedback taps reach back 39 and 58 stream positions, reading the
  // current block's own output when the tap lands inside it. When bypassed the
  // payload passes through, but the returned word still becomes the history.
  function automatic logic [63:0] scramble_block(input logic [63:0] x,
                                                 input logic [57:0] s,
                                                 input logic        bypass);
    logic [63:0] y;
    logic        fb;
    y = '0;
    // Both taps fall in the history
    for (int k = 0; k < 39; k++) begin
      fb        = s[38 - k] ^ s[57 - k];
      y[63 - k] = x[63 - k] ^ (fb & ~bypass);
    end
    // x^39 tap inside the block, x^58 tap still in the history
    for (int k = 39; k < 58; k++) begin
      fb        = y[102 - k] ^ s[57 - k];
      y[63 - k] = x[63 - k] ^ (fb & ~bypass);
    end
    // Both taps inside the block
    for (int k = 58; k < 64; k++) begin
      fb        = y[102 - k] ^ y[121 - k];
      y[63 - k] = x[63 - k] ^ (fb & ~bypass);
    end
    return y;
  endfunction

  logic        w_vld_p0;
  logic [63:0] w_data_p0;
  logic [1:0]  w_hdr_p0;
  logic        w_dis_p0;
  logic [63:0] w_scr_p0;
  logic        w_hdr_bad_p0;

  logic        r_vld_p1;
  logic [63:0] r_data_p1;
  logic [1:0]  r_hdr_p1;
  logic        r_hdr_err_p1;
  logic [57:0] r_hist;

  generate
    if (REGISTER_INPUTS != 0) begin : g_in_reg
      logic        r_vld_p0;
      logic [63:0] r_data_p0;
      logic [1:0]  r_hdr_p0;
      logic        r_dis_p0;

      // ---- stage p0: optional input capture (disable travels with its block)
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_vld_p0  <= 1'b0;
          r_data_p0 <= '0;
          r_hdr_p0  <= '0;
          r_dis_p0  <= 1'b0;
        end else begin
          r_vld_p0  <= in_valid;
          r_data_p0 <= in_data;
          r_hdr_p0  <= in_header;
          r_dis_p0  <= scrambler_disable;
        end
      end

      assign w_vld_p0  = r_vld_p0;
      assign w_data_p0 = r_data_p0;
      assign w_hdr_p0  = r_hdr_p0;
      assign w_dis_p0  = r_dis_p0;
    end else begin : g_in_direct
      assign w_vld_p0  = in_valid;
      assign w_data_p0 = in_data;
      assign w_hdr_p0  = in_header;
      assign w_dis_p0  = scrambler_disable;
    end
  endgenerate

  assign w_scr_p0     = scramble_block(w_data_p0, r_hist, w_dis_p0);
  assign w_hdr_bad_p0 = (w_hdr_p0[1] == w_hdr_p0[0]);

  // ---- stage p1: output register, history update and sticky header error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld_p1     <= 1'b0;
      r_data_p1    <= '0;
      r_hdr_p1     <= '0;
      r_hist       <= '0;
      r_hdr_err_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_vld_p0;
      if (w_vld_p0) begin
        r_data_p1 <= w_scr_p0;
        r_hdr_p1  <= w_hdr_p0;
        // newest 58 transmitted bits are the low end of the output word
        r_hist    <= w_scr_p0[57:0];
        if (w_hdr_bad_p0) begin
          r_hdr_err_p1 <= 1'b1;
        end
      end
    end
  end

  assign out_valid    = r_vld_p1;
  assign out_data     = r_data_p1;
  assign out_header   = r_hdr_p1;
  assign out_charisk  = 4'b0000;
  assign header_error = r_hdr_err_p1;

endmodule

// File: tb/tb_jesd204_tx_scrambler_64b66b.sv
// Bench for jesd204_tx_scrambler_64b66b: one instance per latency setting,
// shared stimulus, bit-serial reference scrambler feeding per-DUT scoreboards,
// plus a bit-serial descrambler on the latency-1 output stream.

module tb_jesd204_tx_scrambler_64b66b;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  h;
    logic        bad;
    logic [63:0] x;
    logic        dis;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        scrambler_disable = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [1:0]  in_header = '0;

  logic        o0_ov, o1_ov;
  logic [63:0] o0_od, o1_od;
  logic [1:0]  o0_oh, o1_oh;
  logic [3:0]  o0_ck, o1_ck;
  logic        o0_err, o1_err;

  int n_cmp = 0;
  int n_mis = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [57:0] ms = '0;
  logic [57:0] ds = '0;
  logic        desc_on = 1'b0;
  int          desc_cnt = 0;
  logic        ev0 = 1'b0, ev1 = 1'b0, ev1d = 1'b0;
  logic        err_exp [2] = '{1'b0, 1'b0};
  logic [63:0] last_d [2] = '{64'd0, 64'd0};
  logic [1:0]  last_h [2] = '{2'd0, 2'd0};

  always #5 clk = ~clk;

  jesd204_tx_scrambler_64b66b #(.REGISTER_INPUTS(0)) u0 (
    .clk(clk), .resetn(resetn), .scrambler_disable(scrambler_disable),
    .in_valid(in_valid), .in_data(in_data), .in_header(in_header),
    .out_valid(o0_ov), .out_data(o0_od), .out_header(o0_oh),
    .out_charisk(o0_ck), .header_error(o0_err)
  );

  jesd204_tx_scrambler_64b66b #(.REGISTER_INPUTS(1)) u1 (
    .clk(clk), .resetn(resetn), .scrambler_disable(scrambler_disable),
    .in_valid(in_valid), .in_data(in_data), .in_header(in_header),
    .out_valid(o1_ov), .out_data(o1_od), .out_header(o1_oh),
    .out_charisk(o1_ck), .header_error(o1_err)
  );

  task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Serial reference scrambler: y = x ^ y(-39) ^ y(-58), bit 63 first.
  task automatic model_block(input logic [63:0] x, input logic dis, output logic [63:0] y);
    logic b;
    y = '0;
    for (int i = 63; i >= 0; i--) begin
      b    = x[i] ^ (dis ? 1'b0 : (ms[38] ^ ms[57]));
      y[i] = b;
      ms   = {ms[56:0], b};
    end
  endtask

  // Serial reference descrambler: x = y ^ y(-39) ^ y(-58).
  task automatic desc_block(input logic [63:0] y, output logic [63:0] x);
    x = '0;
    for (int i = 63; i >= 0; i--) begin
      x[i] = y[i] ^ ds[38] ^ ds[57];
      ds   = {ds[56:0], y[i]};
    end
  endtask

  task automatic check_one(input int id, input logic ov, input logic [63:0] od,
                           input logic [1:0] oh, input logic [3:0] ock,
                           input logic oe, input logic evx);
    exp_t        e;
    logic [63:0] rx;
    string       p;
    p = (id == 0) ? "u0" : "u1";
    ck({p, "_valid"}, ov, evx);
    ck({p, "_charisk"}, ock, 4'b0000);
    if (evx) begin
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        n_cmp++;
        n_mis++;
        $error("FAIL %s_sb_empty observed=valid expected=queued_block", p);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        ck({p, "_data"}, od, e.d);
        ck({p, "_header"}, oh, e.h);
        if (e.dis) ck({p, "_passthru"}, od, e.x);
        if (e.bad) err_exp[id] = 1'b1;
        last_d[id] = e.d;
        last_h[id] = e.h;
        if (id == 0 && desc_on) begin
          desc_block(od, rx);
          if (desc_cnt >= 1 && !e.dis) ck("u0_descrambled", rx, e.x);
          desc_cnt++;
        end
      end
    end else begin
      ck({p, "_hold_data"}, od, last_d[id]);
      ck({p, "_hold_header"}, oh, last_h[id]);
    end
    ck({p, "_header_error"}, oe, err_exp[id]);
  endtask

  task automatic cycle(input logic v, input logic [63:0] d, input logic [1:0] h, input logic dis);
    exp_t        e;
    logic [63:0] y;
    in_valid          = v;
    in_data           = d;
    in_header         = h;
    scrambler_disable = dis;
    if (v) begin
      model_block(d, dis, y);
      e.d   = y;
      e.h   = h;
      e.bad = (h == 2'b00) || (h == 2'b11);
      e.x   = d;
      e.dis = dis;
      q0.push_back(e);
      q1.push_back(e);
    end
    @(posedge clk);
    #1;
    ev0  = v;
    ev1  = ev1d;
    ev1d = v;
    check_one(0, o0_ov, o0_od, o0_oh, o0_ck, o0_err, ev0);
    check_one(1, o1_ov, o1_od, o1_oh, o1_ck, o1_err, ev1);
  endtask

  task automatic check_reset_state(input string tag);
    ck({tag, "_u0_valid"}, o0_ov, 1'b0);
    ck({tag, "_u0_data"}, o0_od, 64'd0);
    ck({tag, "_u0_header"}, o0_oh, 2'b00);
    ck({tag, "_u0_err"}, o0_err, 1'b0);
    ck({tag, "_u1_valid"}, o1_ov, 1'b0);
    ck({tag, "_u1_data"}, o1_od, 64'd0);
    ck({tag, "_u1_header"}, o1_oh, 2'b00);
    ck({tag, "_u1_err"}, o1_err, 1'b0);
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    ms = '0;
    ev0 = 1'b0; ev1 = 1'b0; ev1d = 1'b0;
    err_exp = '{1'b0, 1'b0};
    last_d  = '{64'd0, 64'd0};
    last_h  = '{2'd0, 2'd0};
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [1:0] rnd_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    int          nblk;
    logic        v;
    logic [63:0] seed_ds;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    resetn = 1'b1;

    // Known vectors from S=0
    cycle(1'b1, 64'h8000_0000_0000_0000, 2'b01, 1'b0);
    ck("tp1_u0_data", o0_od, 64'h8000_0000_0100_0020);
    ck("tp1_u0_header", o0_oh, 2'b01);
    cycle(1'b1, 64'h0000_0000_0000_0000, 2'b01, 1'b0);
    ck("tp2_u0_data", o0_od, 64'h0002_0000_0000_0C00);
    ck("tp1_u1_data", o1_od, 64'h8000_0000_0100_0020);
    cycle(1'b0, 64'h0, 2'b00, 1'b0);
    ck("tp2_u1_data", o1_od, 64'h0002_0000_0000_0C00);
    ck("tp_idle_u0_hold", o0_od, 64'h0002_0000_0000_0C00);
    cycle(1'b0, 64'h0, 2'b00, 1'b0);

    // Illegal header sets a sticky error that survives legal blocks
    cycle(1'b1, rnd64(), 2'b11, 1'b0);
    ck("err_set_u0", o0_err, 1'b1);
    cycle(1'b1, rnd64(), 2'b01, 1'b0);
    ck("err_set_u1", o1_err, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd64(), rnd_hdr(), 1'b0);
    ck("err_sticky_u0", o0_err, 1'b1);
    ck("err_sticky_u1", o1_err, 1'b1);

    // Random blocks with gaps; descrambler starts from arbitrary history
    seed_ds  = rnd64();
    ds       = seed_ds[57:0];
    desc_on  = 1'b1;
    desc_cnt = 0;
    nblk     = 0;
    while (nblk < 10000) begin
      v = ($urandom_range(0, 3) != 0);
      cycle(v, rnd64(), rnd_hdr(), 1'b0);
      if (v) nblk++;
    end

    // Pass-through, then toggle back to scrambling mid-stream
    for (int i = 0; i < 40; i++) cycle(($urandom_range(0, 4) != 0), rnd64(), rnd_hdr(), 1'b1);
    for (int i = 0; i < 40; i++) cycle(($urandom_range(0, 4) != 0), rnd64(), rnd_hdr(), 1'b0);
    desc_on = 1'b0;

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd64(), rnd_hdr(), 1'b0);
    #2;
    resetn   = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_state("midrst");
    clear_model();
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // First block after release scrambles from S=0
    cycle(1'b1, 64'h8000_0000_0000_0000, 2'b01, 1'b0);
    ck("rst_first_u0", o0_od, 64'h8000_0000_0100_0020);
    cycle(1'b1, 64'h0000_0000_0000_0000, 2'b10, 1'b0);
    ck("rst_first_u1", o1_od, 64'h8000_0000_0100_0020);
    ck("rst_second_u0", o0_od, 64'h0002_0000_0000_0C00);
    cycle(1'b0, 64'h0, 2'b00, 1'b0);
    ck("rst_second_u1", o1_od, 64'h0002_0000_0000_0C00);
    cycle(1'b0, 64'h0, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/jesd204_tx_scrambler_64b66b.md
# jesd204_tx_scrambler_64b66b

Per-lane JESD204C 64B66B transmit scrambler. It sits in the link layer directly upstream of the Versal GT TX adapter. It takes 64-bit block payloads with 2-bit sync headers and scrambles the payload with the self-synchronous polynomial 1 + x^39 + x^58. It then drives the adapter's `tx_data` / `tx_header` inputs, with `tx_charisk` tied 0 in 64B66B mode. It also checks sync-header legality and reports a sticky error.

## Interface
Parameters:
- `REGISTER_INPUTS`, 0, 1 adds an input register stage (latency 2 instead of 1).

Ports:
- `clk`  in  1  lane/link clock; the only clock.
- `resetn`  in  1  reset; asynchronous assert, active-low.
- `scrambler_disable`  in  1  quasi-static; 1 = payload passes unscrambled.
- `in_valid`  in  1  qualifies `in_data` / `in_header`.
- `in_data`  in  64  block payload; bit 63 is transmitted first.
- `in_header`  in  2  sync header (2'b01 data, 2'b10 control).
- `out_valid`  out  1  qualifies outputs.
- `out_data`  out  64  scrambled payload; feeds adapter `tx_data`.
- `out_header`  out  2  header, delayed to match `out_data`; feeds adapter `tx_header`.
- `out_charisk`  out  4  constant 4'b0.
- `header_error`  out  1  sticky; set by any valid block with header 2'b00 or 2'b11.

## Operation
- Stream order: index k = 0..63 maps to `in_data[63-k]`.
- History register S[57:0] holds the most recent 58 scrambled bits. S[0] is the newest. S[j] is the bit transmitted j+1 positions earlier.
- For each valid block, k runs from 0 to 63 (combinational unroll):
  - y_k = x_k ^ H(k-39) ^ H(k-58).
  - H(m) is y_m for m >= 0 within the current block. Otherwise it is taken from S.
  - `out_data[63-k]` = y_k.
- After the block, S is loaded with y_63..y_6. The new S[0] is y_63.
- Disabled (`scrambler_disable`=1):
  - `out_data` = `in_data`.
  - S is loaded from the unscrambled bits as if they were y. This keeps the history continuous across a toggle.
- `in_valid`=0: S holds, `out_data` / `out_header` hold, `out_valid`=0.
- `out_header` = `in_header`, registered alongside the data. Headers are never scrambled.
- `header_error` is set on the output-register cycle of any valid block with an illegal header. Only reset clears it. The block is still forwarded unchanged.
- No backpressure. The downstream GT consumes one block per valid cycle.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_header`=2'b00, `header_error`=0, S=0. Input stage registers (if present) are also 0.
- Latency from `in_valid` to `out_valid`: 1 cycle with `REGISTER_INPUTS`=0, 2 cycles with 1. `out_valid` is the valid input delayed by that amount.
- Throughput: one block per cycle, with back-to-back blocks at full rate.
- Reset mid-stream: all outputs and S return to reset values immediately (asynchronous). The first block after reset release scrambles from S=0.
- `scrambler_disable` change: takes effect on the next valid block. No blocks are dropped.
- Simultaneous illegal header and reset deassertion edge: the block is processed normally and the error is set.

## Test plan
- Reset, then one valid block with `in_data`=64'h8000_0000_0000_0000 and header 2'b01 -> `out_data`=64'h8000_0000_0100_0020, `out_header`=2'b01, 1 cycle later.
- Follow immediately with `in_data`=0 -> `out_data`=64'h0002_0000_0000_0C00.
- 10k random blocks with random `in_valid` gaps, fed through a reference descrambler (x_k = y_k ^ y_{k-39} ^ y_{k-58}) -> recovered stream equals input. The descrambler self-synchronizes within one block after an arbitrary start.
- `scrambler_disable`=1 with random data -> `out_data`=`in_data` each valid cycle. Toggle to 0 mid-stream -> scrambling continues from history built on the passed-through bits, matching the model.
- Valid block with header 2'b11 -> `header_error`=1 and stays 1 through later legal blocks. Deassert `resetn` -> `header_error`=0.
- `REGISTER_INPUTS`=1 -> same vectors with latency 2. Assert `resetn` low mid-burst -> `out_valid`=0 and `out_data`=0 asynchronously. After release, the first block matches the S=0 model.
